// File: rtl/red_tin_la_pkg.sv
// rtl/red_tin_la_pkg.sv - state enum, default parameters and read-width helper for the capture core (RED_TIN_LA_TIMESTAMP_EN)
package red_tin_la_pkg;

    localparam int LA_DATA_WIDTH_DEF = 128;
    localparam int LA_DEPTH_LOG2_DEF = 9;
    localparam int LA_TS_WIDTH_DEF   = 32;

`ifdef RED_TIN_LA_TIMESTAMP_EN
    localparam bit LA_TS_EN = 1'b1;
`else
    localparam bit LA_TS_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_FILL      = 3'd1,
        ST_WAIT_TRIG = 3'd2,
        ST_POST      = 3'd3,
        ST_DONE      = 3'd4
    } la_state_e;

    // Stored/read word width: sample data, optionally topped with a timestamp
    function automatic int la_read_width(input int data_w, input int ts_w, input bit ts_en);
        return ts_en ? (data_w + ts_w) : data_w;
    endfunction

endpackage

// File: rtl/red_tin_trigger_match.sv
// rtl/red_tin_trigger_match.sv - masked level/edge trigger match with previous-sample history
module red_tin_trigger_match #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clear,
    input  logic                  update,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic [DATA_WIDTH-1:0] trigger_low,
    input  logic [DATA_WIDTH-1:0] trigger_high,
    input  logic [DATA_WIDTH-1:0] trigger_rising,
    input  logic [DATA_WIDTH-1:0] trigger_falling,
    output logic                  match
);

    logic [DATA_WIDTH-1:0] prev_q, prev_d;
    logic                  seen_q, seen_d;

    logic [DATA_WIDTH-1:0] rise_bits, fall_bits;
    logic                  level_ok, rise_ok, fall_ok, edge_used;

    // History tracks the last valid sample since arm; clear wins over update
    always_comb begin
        prev_d = prev_q;
        seen_d = seen_q;
        if (clear) begin
            prev_d = '0;
            seen_d = 1'b0;
        end else if (update) begin
            prev_d = din;
            seen_d = 1'b1;
        end
    end

    // History registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            prev_q <= '0;
            seen_q <= 1'b0;
        end else begin
            prev_q <= prev_d;
            seen_q <= seen_d;
        end
    end

    // AND of every masked condition; edges are meaningless until a previous sample exists
    always_comb begin
        rise_bits = din & ~prev_q;
        fall_bits = ~din & prev_q;
        level_ok  = ((din & trigger_low) == '0) && ((~din & trigger_high) == '0);
        rise_ok   = ((trigger_rising & ~rise_bits) == '0);
        fall_ok   = ((trigger_falling & ~fall_bits) == '0);
        edge_used = |(trigger_rising | trigger_falling);
        match     = level_ok && rise_ok && fall_ok && (!edge_used || seen_q);
    end

endmodule

// File: rtl/red_tin_la_core.sv
// rtl/red_tin_la_core.sv - logic-analyzer capture core with pretrigger buffer; RED_TIN_LA_TIMESTAMP_EN adds per-sample timestamps
module red_tin_la_core
    import red_tin_la_pkg::*;
#(
    parameter int DATA_WIDTH = LA_DATA_WIDTH_DEF,
    parameter int DEPTH_LOG2 = LA_DEPTH_LOG2_DEF,
    parameter int TS_WIDTH   = LA_TS_WIDTH_DEF,
    localparam int RW        = la_read_width(DATA_WIDTH, TS_WIDTH, LA_TS_EN)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  din_valid,
    input  logic [DATA_WIDTH-1:0] trigger_low,
    input  logic [DATA_WIDTH-1:0] trigger_high,
    input  logic [DATA_WIDTH-1:0] trigger_rising,
    input  logic [DATA_WIDTH-1:0] trigger_falling,
    input  logic [DEPTH_LOG2-1:0] pretrigger,
    input  logic                  arm,
    output logic                  armed,
    output logic                  triggered,
    output logic                  done,
    input  logic                  read_en,
    input  logic [DEPTH_LOG2-1:0] read_addr,
    output logic [RW-1:0]         read_data,
    output logic                  read_valid
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2-1:0] LAST_IDX = '1;

    la_state_e state_q, state_d;

    logic [DEPTH_LOG2-1:0] p_q, p_d;
    logic [DEPTH_LOG2-1:0] wr_ptr_q, wr_ptr_d;
    logic [DEPTH_LOG2-1:0] cnt_q, cnt_d;
    logic [DEPTH_LOG2-1:0] trig_ptr_q, trig_ptr_d;
    logic                  armed_q, armed_d;
    logic                  triggered_q, triggered_d;
    logic                  done_q, done_d;
    logic                  read_valid_q, read_valid_d;
    logic [RW-1:0]         read_data_q;

    logic [RW-1:0]         mem [DEPTH];

    logic                  capturing, wr_en, arm_accept, match, trig_hit, rd_fire;
    logic [DEPTH_LOG2-1:0] cnt_inc, rd_phys;
    logic [RW-1:0]         wdata;

    assign capturing  = (state_q == ST_FILL) || (state_q == ST_WAIT_TRIG) || (state_q == ST_POST);
    assign wr_en      = capturing && din_valid;
    assign arm_accept = arm && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign trig_hit   = (state_q == ST_WAIT_TRIG) && din_valid && match;
    assign cnt_inc    = cnt_q + 1'b1;
    assign rd_fire    = read_en && (state_q == ST_DONE);
    // Logical index P lands on the trigger sample
    assign rd_phys    = trig_ptr_q - p_q + read_addr;

    red_tin_trigger_match #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_match (
        .clk             (clk),
        .reset           (reset),
        .clear           (arm_accept),
        .update          (wr_en),
        .din             (din),
        .trigger_low     (trigger_low),
        .trigger_high    (trigger_high),
        .trigger_rising  (trigger_rising),
        .trigger_falling (trigger_falling),
        .match           (match)
    );

`ifdef RED_TIN_LA_TIMESTAMP_EN
    logic [TS_WIDTH-1:0] ts_q, ts_d;

    // Timestamp clears on arm and counts armed cycles, sticking at all-ones
    always_comb begin
        ts_d = ts_q;
        if (arm_accept) begin
            ts_d = '0;
        end else if (armed_q && (ts_q != '1)) begin
            ts_d = ts_q + 1'b1;
        end
    end

    // Timestamp register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_d;
        end
    end

    assign wdata = {ts_q, din};
`else
    assign wdata = din;
`endif

    // Capture sequencing: pretrigger fill, trigger search, post-trigger fill
    always_comb begin
        state_d      = state_q;
        p_d          = p_q;
        wr_ptr_d     = wr_ptr_q;
        cnt_d        = cnt_q;
        trig_ptr_d   = trig_ptr_q;
        armed_d      = armed_q;
        triggered_d  = triggered_q;
        done_d       = done_q;
        read_valid_d = rd_fire;

        if (wr_en) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (arm) begin
                    state_d     = ST_FILL;
                    // pretrigger is DEPTH_LOG2 wide, so it never exceeds DEPTH-1
                    p_d         = pretrigger;
                    wr_ptr_d    = '0;
                    cnt_d       = '0;
                    armed_d     = 1'b1;
                    triggered_d = 1'b0;
                    done_d      = 1'b0;
                end
            end
            ST_FILL: begin
                if (din_valid) begin
                    cnt_d = cnt_inc;
                end
                // P=0 spends exactly one cycle here regardless of din_valid
                if ((p_q == '0) || (din_valid && (cnt_inc == p_q))) begin
                    state_d = ST_WAIT_TRIG;
                    cnt_d   = '0;
                end
            end
            ST_WAIT_TRIG: begin
                if (trig_hit) begin
                    trig_ptr_d  = wr_ptr_q;
                    triggered_d = 1'b1;
                    cnt_d       = '0;
                    if (p_q == LAST_IDX) begin
                        state_d = ST_DONE;
                        armed_d = 1'b0;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_POST;
                    end
                end
            end
            ST_POST: begin
                if (din_valid) begin
                    cnt_d = cnt_inc;
                    // DEPTH-1-P in DEPTH_LOG2 bits is simply ~P
                    if (cnt_inc == ~p_q) begin
                        state_d = ST_DONE;
                        armed_d = 1'b0;
                        done_d  = 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                armed_d = 1'b0;
            end
        endcase
    end

    // Control and status registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            p_q          <= '0;
            wr_ptr_q     <= '0;
            cnt_q        <= '0;
            trig_ptr_q   <= '0;
            armed_q      <= 1'b0;
            triggered_q  <= 1'b0;
            done_q       <= 1'b0;
            read_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            p_q          <= p_d;
            wr_ptr_q     <= wr_ptr_d;
            cnt_q        <= cnt_d;
            trig_ptr_q   <= trig_ptr_d;
            armed_q      <= armed_d;
            triggered_q  <= triggered_d;
            done_q       <= done_d;
            read_valid_q <= read_valid_d;
        end
    end

    // Sample buffer write port; contents survive reset
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= wdata;
        end
    end

    // Registered read port; holds the last word between valid reads
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            read_data_q <= '0;
        end else if (rd_fire) begin
            read_data_q <= mem[rd_phys];
        end
    end

    assign armed      = armed_q;
    assign triggered  = triggered_q;
    assign done       = done_q;
    assign read_valid = read_valid_q;
    assign read_data  = read_data_q;

endmodule

// File: tb/tb_red_tin_la_core.sv
// tb/tb_red_tin_la_core.sv - directed bench for red_tin_la_core at DATA_WIDTH=8, DEPTH_LOG2=4
module tb_red_tin_la_core;

    localparam int DW = 8;
    localparam int DL = 4;
    localparam int TW = 32;
`ifdef RED_TIN_LA_TIMESTAMP_EN
    localparam int RW = TW + DW;
`else
    localparam int RW = DW;
`endif

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] din;
    logic          din_valid;
    logic [DW-1:0] trigger_low, trigger_high, trigger_rising, trigger_falling;
    logic [DL-1:0] pretrigger;
    logic          arm;
    logic          armed, triggered, done;
    logic          read_en;
    logic [DL-1:0] read_addr;
    logic [RW-1:0] read_data;
    logic          read_valid;

    int n_vec = 0;
    int n_err = 0;

    red_tin_la_core #(
        .DATA_WIDTH (DW),
        .DEPTH_LOG2 (DL),
        .TS_WIDTH   (TW)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .din             (din),
        .din_valid       (din_valid),
        .trigger_low     (trigger_low),
        .trigger_high    (trigger_high),
        .trigger_rising  (trigger_rising),
        .trigger_falling (trigger_falling),
        .pretrigger      (pretrigger),
        .arm             (arm),
        .armed           (armed),
        .triggered       (triggered),
        .done            (done),
        .read_en         (read_en),
        .read_addr       (read_addr),
        .read_data       (read_data),
        .read_valid      (read_valid)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic read_idx(input int i);
        read_en   = 1'b1;
        read_addr = i[DL-1:0];
        tick();
        read_en   = 1'b0;
    endtask

    // P=4, trigger on bit7 high, counting data from 8'h70; 8'h80 arrives after the fill
    task automatic capture_count(input string tag);
        int          edges;
        logic [31:0] prev_ts;
        prev_ts         = '0;
        pretrigger      = 4'd4;
        trigger_low     = 8'h00;
        trigger_high    = 8'h80;
        trigger_rising  = 8'h00;
        trigger_falling = 8'h00;
        din_valid       = 1'b1;
        din             = 8'h70;
        arm             = 1'b1;
        tick();
        arm = 1'b0;
        check({tag, "_armed"}, armed, 1);
        check({tag, "_trig_clr"}, triggered, 0);
        for (int v = 8'h71; v < 8'h80; v++) begin
            din = v[7:0];
            tick();
        end
        check({tag, "_no_trig_early"}, triggered, 0);
        din = 8'h80;
        tick();
        edges = 1;
        check({tag, "_triggered"}, triggered, 1);
        while (!done && edges < 40) begin
            din = din + 8'h01;
            tick();
            edges++;
        end
        check({tag, "_done_latency"}, edges, 12);
        check({tag, "_armed_off"}, armed, 0);
        for (int i = 0; i < 16; i++) begin
            read_idx(i);
            check({tag, "_rvalid"}, read_valid, 1);
            check({tag, "_rdata"}, read_data[DW-1:0], 8'h7C + i);
`ifdef RED_TIN_LA_TIMESTAMP_EN
            if (i > 0) begin
                check({tag, "_ts_step"}, read_data[RW-1:DW] - prev_ts, 1);
            end
            prev_ts = read_data[RW-1:DW];
`endif
        end
        tick();
        check({tag, "_rvalid_low"}, read_valid, 0);
        check({tag, "_rdata_hold"}, read_data[DW-1:0], 8'h8B);
    endtask

    initial begin
        int edges;
        int s;
        int cyc;

        reset           = 1'b1;
        din             = '0;
        din_valid       = 1'b0;
        trigger_low     = '0;
        trigger_high    = '0;
        trigger_rising  = '0;
        trigger_falling = '0;
        pretrigger      = '0;
        arm             = 1'b0;
        read_en         = 1'b0;
        read_addr       = '0;
        tick();
        tick();
        check("rst_armed", armed, 0);
        check("rst_triggered", triggered, 0);
        check("rst_done", done, 0);
        check("rst_rvalid", read_valid, 0);
        check("rst_rdata", read_data[DW-1:0], 0);
        reset = 1'b0;
        tick();

        // Level trigger with pretrigger window
        capture_count("A");

        // P=0 rising edge on bit0; no history for the first valid sample
        pretrigger      = 4'd0;
        trigger_high    = 8'h00;
        trigger_rising  = 8'h01;
        din_valid       = 1'b0;
        arm             = 1'b1;
        tick();
        arm = 1'b0;
        check("B_trig_clr", triggered, 0);
        check("B_done_clr", done, 0);
        read_en = 1'b1;
        tick();
        read_en = 1'b0;
        check("B_rvalid_not_done", read_valid, 0);
        din_valid = 1'b1;
        din       = 8'h01;
        tick();
        check("B_first_no_trig", triggered, 0);
        din = 8'h00;
        tick();
        din = 8'h01;
        tick();
        check("B_triggered", triggered, 1);
        edges = 0;
        while (!done && edges < 40) begin
            din = (edges % 2 == 0) ? 8'h00 : 8'h01;
            tick();
            edges++;
        end
        check("B_post_count", edges, 15);
        read_idx(0);
        check("B_idx0", read_data[DW-1:0], 8'h01);
        read_idx(1);
        check("B_idx1", read_data[DW-1:0], 8'h00);
        read_idx(2);
        check("B_idx2", read_data[DW-1:0], 8'h01);
        read_idx(15);
        check("B_idx15", read_data[DW-1:0], 8'h00);

        // P=15, all-low trigger: straight to DONE, no writes afterwards
        pretrigger     = 4'd15;
        trigger_rising = 8'h00;
        trigger_low    = 8'hFF;
        din_valid      = 1'b1;
        din            = 8'h55;
        arm            = 1'b1;
        tick();
        arm = 1'b0;
        for (int v = 1; v <= 15; v++) begin
            din = v[7:0];
            tick();
        end
        check("C_no_trig_fill", triggered, 0);
        check("C_armed", armed, 1);
        din = 8'h00;
        tick();
        check("C_triggered", triggered, 1);
        check("C_done", done, 1);
        check("C_armed_off", armed, 0);
        din = 8'hAA;
        tick();
        tick();
        tick();
        read_idx(15);
        check("C_idx15", read_data[DW-1:0], 8'h00);
        read_idx(0);
        check("C_idx0", read_data[DW-1:0], 8'h01);
        read_idx(14);
        check("C_idx14", read_data[DW-1:0], 8'h0F);

        // Gapped valid; invalid cycles carry a value that would trigger; arm pulses in POST
        pretrigger   = 4'd2;
        trigger_low  = 8'h00;
        trigger_high = 8'h08;
        din_valid    = 1'b1;
        din          = 8'h00;
        arm          = 1'b1;
        tick();
        arm = 1'b0;
        s   = 1;
        cyc = 0;
        while (!done && cyc < 200) begin
            if (cyc % 2 == 0) begin
                din_valid = 1'b1;
                din       = s[7:0];
                s++;
            end else begin
                din_valid = 1'b0;
                din       = 8'hEE;
            end
            arm = triggered && (cyc % 6 == 3);
            tick();
            cyc++;
        end
        arm       = 1'b0;
        din_valid = 1'b0;
        check("D_done", done, 1);
        check("D_last_sample", s, 32'h16);
        read_idx(0);
        check("D_idx0", read_data[DW-1:0], 8'h06);
        read_idx(2);
        check("D_idx2", read_data[DW-1:0], 8'h08);
        read_idx(8);
        check("D_idx8", read_data[DW-1:0], 8'h0E);
        read_idx(15);
        check("D_idx15", read_data[DW-1:0], 8'h15);

        // Reset mid-POST, then a fresh capture
        pretrigger   = 4'd4;
        trigger_high = 8'h80;
        din_valid    = 1'b1;
        din          = 8'h70;
        arm          = 1'b1;
        tick();
        arm = 1'b0;
        for (int v = 8'h71; v <= 8'h83; v++) begin
            din = v[7:0];
            tick();
        end
        check("E_in_post", armed, 1);
        reset = 1'b1;
        #1;
        check("E_rst_armed", armed, 0);
        check("E_rst_triggered", triggered, 0);
        check("E_rst_done", done, 0);
        check("E_rst_rvalid", read_valid, 0);
        check("E_rst_rdata", read_data[DW-1:0], 0);
        tick();
        reset = 1'b0;
        din   = 8'hFF;
        tick();
        tick();
        check("E_idle_armed", armed, 0);
        check("E_idle_done", done, 0);
        capture_count("E");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
